// File: rtl/hdlc_tx_framer.sv
// hdlc_tx_framer: serial HDLC transmit framer. Builds flag, zero-stuffed
// payload, optional CRC-16/X-25 FCS (macro HDLC_TX_FCS_EN) and closing flag,
// plus the abort pattern and all-ones idle line.
// Ports: Clk, Rst (sync, active high); TxEN enable; Tx_Data/Tx_Valid/Tx_Last/
// Tx_Ready byte handshake; Tx_AbortFrame abort request; Tx registered line;
// Tx_Busy not idle; Tx_Done / Tx_AbortedTrans end-of-frame / end-of-abort pulses.
module hdlc_tx_framer (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       TxEN,
   input  logic [7:0] Tx_Data,
   input  logic       Tx_Valid,
   input  logic       Tx_Last,
   output logic       Tx_Ready,
   input  logic       Tx_AbortFrame,
   output logic       Tx,
   output logic       Tx_Busy,
   output logic       Tx_Done,
   output logic       Tx_AbortedTrans
);

   typedef enum logic [2:0] {
      IDLE, START_FLAG, DATA, FCS, END_FLAG, ABORT
   } state_t;

   // flag in time order (bit 0 first): 0,1,1,1,1,1,1,0
   localparam logic [7:0] FLAG = 8'h7E;

   state_t     state, state_n;
   // flags/abort: pattern bits already sent; DATA/FCS: bits of sh sent
   logic [3:0] cnt, cnt_n;
   logic [7:0] sh, sh_n;
   logic [2:0] ones, ones_n;
   logic       last_q, last_n;
   logic       stuff_q, stuff_n;
   logic       tx_n, done_n, abrt_n;
   logic       abort_req, go_abort, load;

`ifdef HDLC_TX_FCS_EN
   logic [15:0] crc, crc_n;
   logic        hi_q, hi_n;
   logic [7:0]  fcs_b;

   function automatic logic [15:0] crc_byte(input logic [15:0] c,
                                            input logic [7:0]  d);
      logic [15:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         r = (r >> 1) ^ ((r[0] ^ d[i]) ? 16'h8408 : 16'h0000);
      return r;
   endfunction

   assign fcs_b = (state == DATA) ? ~crc[7:0] : ~crc[15:8];
`endif

   assign Tx_Busy   = (state != IDLE);
   assign abort_req = Tx_AbortFrame || !TxEN;

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      sh_n     = sh;
      ones_n   = ones;
      last_n   = last_q;
      stuff_n  = 1'b0;
      tx_n     = 1'b1;
      done_n   = 1'b0;
      abrt_n   = 1'b0;
      Tx_Ready = 1'b0;
      go_abort = 1'b0;
      load     = 1'b0;
`ifdef HDLC_TX_FCS_EN
      crc_n    = crc;
      hi_n     = hi_q;
`endif
      case (state)
         IDLE: begin
            if (TxEN && Tx_Valid) begin
               state_n = START_FLAG;
               cnt_n   = 4'd0;
               ones_n  = 3'd0;
`ifdef HDLC_TX_FCS_EN
               crc_n   = 16'hFFFF;
               hi_n    = 1'b0;
`endif
            end
         end
         START_FLAG: begin
            Tx_Ready = (cnt == 4'd8);
            if (abort_req || (Tx_Ready && !Tx_Valid)) go_abort = 1'b1;
            else if (Tx_Ready) load = 1'b1;
            else begin
               tx_n  = FLAG[cnt[2:0]];
               cnt_n = cnt + 4'd1;
            end
         end
         DATA, FCS: begin
            // last bit of a byte on the line, and not a stuff bit
            Tx_Ready = (state == DATA) && (cnt == 4'd8)
                       && !stuff_q && !last_q;
            if (abort_req || (Tx_Ready && !Tx_Valid)) go_abort = 1'b1;
            else if (Tx_Ready) load = 1'b1;
            else if (ones == 3'd5) begin
               tx_n    = 1'b0;
               ones_n  = 3'd0;
               stuff_n = 1'b1;
            end else if (cnt != 4'd8) begin
               tx_n   = sh[cnt[2:0]];
               cnt_n  = cnt + 4'd1;
               ones_n = sh[cnt[2:0]] ? ones + 3'd1 : 3'd0;
            end else if (state == DATA && !last_q) go_abort = 1'b1;
`ifdef HDLC_TX_FCS_EN
            else if (state == DATA || !hi_q) begin
               state_n = FCS;
               hi_n    = (state == FCS);
               sh_n    = fcs_b;
               tx_n    = fcs_b[0];
               cnt_n   = 4'd1;
               ones_n  = fcs_b[0] ? ones + 3'd1 : 3'd0;
            end
`endif
            else begin
               state_n = END_FLAG;
               tx_n    = 1'b0;
               cnt_n   = 4'd1;
               ones_n  = 3'd0;
            end
         end
         END_FLAG: begin
            if (cnt != 4'd8) begin
               tx_n   = FLAG[cnt[2:0]];
               cnt_n  = cnt + 4'd1;
               done_n = (cnt == 4'd7);
            end else state_n = IDLE;
         end
         ABORT: begin
            if (cnt != 4'd8) begin
               cnt_n  = cnt + 4'd1;
               abrt_n = (cnt == 4'd7);
            end else state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // abort pattern bit 0 goes out right after the current bit
      if (go_abort) begin
         state_n = ABORT;
         tx_n    = 1'b0;
         cnt_n   = 4'd1;
         ones_n  = 3'd0;
      end

      // a stuff bit owed by the previous byte goes out before bit 0
      if (load) begin
         state_n = DATA;
         sh_n    = Tx_Data;
         last_n  = Tx_Last;
`ifdef HDLC_TX_FCS_EN
         crc_n   = crc_byte(crc, Tx_Data);
`endif
         if (ones == 3'd5) begin
            tx_n    = 1'b0;
            ones_n  = 3'd0;
            stuff_n = 1'b1;
            cnt_n   = 4'd0;
         end else begin
            tx_n   = Tx_Data[0];
            ones_n = Tx_Data[0] ? ones + 3'd1 : 3'd0;
            cnt_n  = 4'd1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state           <= IDLE;
         cnt             <= 4'd0;
         sh              <= 8'd0;
         ones            <= 3'd0;
         last_q          <= 1'b0;
         stuff_q         <= 1'b0;
         Tx              <= 1'b1;
         Tx_Done         <= 1'b0;
         Tx_AbortedTrans <= 1'b0;
`ifdef HDLC_TX_FCS_EN
         crc             <= 16'h0000;
         hi_q            <= 1'b0;
`endif
      end else begin
         state           <= state_n;
         cnt             <= cnt_n;
         sh              <= sh_n;
         ones            <= ones_n;
         last_q          <= last_n;
         stuff_q         <= stuff_n;
         Tx              <= tx_n;
         Tx_Done         <= done_n;
         Tx_AbortedTrans <= abrt_n;
`ifdef HDLC_TX_FCS_EN
         crc             <= crc_n;
         hi_q            <= hi_n;
`endif
      end
   end

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// tb_hdlc_tx_framer: scoreboard bench for hdlc_tx_framer; expected line bits
// are queued per frame and popped/compared once per cycle.
module tb_hdlc_tx_framer;

   logic       Clk = 1'b0;
   logic       Rst, TxEN, Tx_Valid, Tx_Last, Tx_AbortFrame;
   logic [7:0] Tx_Data;
   logic       Tx_Ready, Tx, Tx_Busy, Tx_Done, Tx_AbortedTrans;

   int checks = 0;
   int errors = 0;
   int consumed;

   typedef logic [7:0] bq_t[$];
   typedef struct packed {
      logic tx;
      logic stuff;
      logic done;
      logic abrt;
   } exp_t;

   exp_t exp_q[$];
   logic obs_q[$];

   always #5 Clk = ~Clk;

   hdlc_tx_framer dut (
      .Clk(Clk), .Rst(Rst), .TxEN(TxEN), .Tx_Data(Tx_Data),
      .Tx_Valid(Tx_Valid), .Tx_Last(Tx_Last), .Tx_Ready(Tx_Ready),
      .Tx_AbortFrame(Tx_AbortFrame), .Tx(Tx), .Tx_Busy(Tx_Busy),
      .Tx_Done(Tx_Done), .Tx_AbortedTrans(Tx_AbortedTrans)
   );

   function automatic logic [15:0] fcs_x25(input bq_t d);
      logic [15:0] c;
      c = 16'hFFFF;
      foreach (d[i])
         for (int b = 0; b < 8; b++)
            if (c[0] ^ d[i][b]) c = (c >> 1) ^ 16'h8408;
            else c = c >> 1;
      return ~c;
   endfunction

   task automatic push(input logic b, input logic s,
                       input logic dn, input logic ab);
      exp_t e;
      e.tx = b; e.stuff = s; e.done = dn; e.abrt = ab;
      exp_q.push_back(e);
   endtask

   task automatic push_pat(input logic [7:0] pat, input logic dn,
                           input logic ab);
      for (int i = 0; i < 8; i++)
         push(pat[i], 1'b0, dn && i == 7, ab && i == 7);
   endtask

   task automatic build_expected(input bq_t data, input int avail,
                                 input int abort_pos);
      logic s[$];
      int   ones;
      logic full;
      logic [15:0] f;
      exp_q.delete();
      full = (avail >= data.size());
      push(1'b1, 1'b0, 1'b0, 1'b0);
      push_pat(8'h7E, 1'b0, 1'b0);
      for (int i = 0; i < avail && i < data.size(); i++)
         for (int b = 0; b < 8; b++) s.push_back(data[i][b]);
`ifdef HDLC_TX_FCS_EN
      if (full) begin
         f = fcs_x25(data);
         for (int b = 0; b < 16; b++) s.push_back(f[b]);
      end
`else
      f = 16'h0;
`endif
      ones = 0;
      foreach (s[k]) begin
         push(s[k], 1'b0, 1'b0, 1'b0);
         ones = s[k] ? ones + 1 : 0;
         if (ones == 5) begin
            if (full || k != s.size() - 1) push(1'b0, 1'b1, 1'b0, 1'b0);
            ones = 0;
         end
      end
      if (full) push_pat(8'h7E, 1'b1, 1'b0);
      else push_pat(8'hFE, 1'b0, 1'b1);
      push(1'b1, 1'b0, 1'b0, 1'b0);
      if (abort_pos >= 0) begin
         while (exp_q.size() > abort_pos + 1) void'(exp_q.pop_back());
         push_pat(8'hFE, 1'b0, 1'b1);
         push(1'b1, 1'b0, 1'b0, 1'b0);
      end
   endtask

   // starts at a negedge with the line idle
   task automatic run_frame(input bq_t data, input int avail,
                            input int abort_pos, input int exp_cons,
                            input string name);
      int   idx, pos;
      logic hs;
      exp_t e;
      build_expected(data, avail, abort_pos);
      obs_q.delete();
      consumed = 0;
      idx = 0;
      pos = 0;
      TxEN = 1'b1;
      Tx_Valid = (avail > 0);
      Tx_Data = data[0];
      Tx_Last = (data.size() == 1);
      while (exp_q.size() > 0) begin
         hs = Tx_Valid && Tx_Ready && TxEN && !Tx_AbortFrame;
         @(negedge Clk);
         e = exp_q.pop_front();
         obs_q.push_back(Tx);
         checks++;
         if (Tx !== e.tx || Tx_Done !== e.done ||
             Tx_AbortedTrans !== e.abrt) begin
            errors++;
            $display("FAIL %s pos %0d: tx/done/abrt=%b%b%b required %b%b%b",
                     name, pos, Tx, Tx_Done, Tx_AbortedTrans,
                     e.tx, e.done, e.abrt);
         end
         if (e.stuff) begin
            checks++;
            if (Tx_Ready !== 1'b0) begin
               errors++;
               $display("FAIL %s ready_in_stuff pos %0d: ready=%b required 0",
                        name, pos, Tx_Ready);
            end
         end
         Tx_AbortFrame = 1'b0;
         if (hs) begin
            idx++;
            consumed++;
         end
         if (idx < avail && idx < data.size()) begin
            Tx_Data = data[idx];
            Tx_Last = (idx == data.size() - 1);
         end else begin
            Tx_Valid = 1'b0;
            Tx_Last = 1'b0;
         end
         if (pos == abort_pos) begin
            Tx_AbortFrame = 1'b1;
            Tx_Valid = 1'b0;
         end
         pos++;
      end
      checks++;
      if (Tx_Busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_after: busy=%b required 0", name, Tx_Busy);
      end
      checks++;
      if (consumed != exp_cons) begin
         errors++;
         $display("FAIL %s consumed: %0d required %0d", name, consumed,
                  exp_cons);
      end
   endtask

   // receiver model: opening flag, de-stuff, stop at the closing flag
   task automatic rx_check(input bq_t want, input string name);
      int   j, ones;
      logic bits[$];
      logic closed;
      logic [7:0] b8;
      j = 0;
      ones = 0;
      closed = 1'b0;
      while (j < obs_q.size() && obs_q[j] == 1'b1) j++;
      j += 8;
      for (; j < obs_q.size() && !closed; j++) begin
         if (ones == 5) begin
            if (obs_q[j] == 1'b0) begin
               ones = 0;
               continue;
            end
            closed = 1'b1;
         end else begin
            bits.push_back(obs_q[j]);
            ones = obs_q[j] ? ones + 1 : 0;
         end
      end
      repeat (6) if (bits.size() > 0) void'(bits.pop_back());
      checks++;
      if (!closed || bits.size() != 8 * want.size()) begin
         errors++;
         $display("FAIL %s rx_len: closed=%b bits=%0d required %0d",
                  name, closed, bits.size(), 8 * want.size());
      end else begin
         foreach (want[i]) begin
            for (int b = 0; b < 8; b++) b8[b] = bits[8 * i + b];
            checks++;
            if (b8 !== want[i]) begin
               errors++;
               $display("FAIL %s rx_byte %0d: %h required %h", name, i, b8,
                        want[i]);
            end
         end
      end
   endtask

   task automatic frame_ok(input bq_t data, input string name);
      bq_t want;
      logic [15:0] f;
      run_frame(data, data.size(), -1, data.size(), name);
      want = data;
`ifdef HDLC_TX_FCS_EN
      f = fcs_x25(data);
      want.push_back(f[7:0]);
      want.push_back(f[15:8]);
`else
      f = 16'h0;
`endif
      rx_check(want, name);
   endtask

   task automatic check_idle(input string name);
      checks++;
      if (Tx !== 1'b1 || Tx_Ready !== 1'b0 || Tx_Busy !== 1'b0 ||
          Tx_Done !== 1'b0 || Tx_AbortedTrans !== 1'b0) begin
         errors++;
         $display("FAIL %s: tx/rdy/busy/done/abrt=%b%b%b%b%b required 10000",
                  name, Tx, Tx_Ready, Tx_Busy, Tx_Done, Tx_AbortedTrans);
      end
   endtask

   task automatic test_reset;
      Rst = 1'b1; TxEN = 1'b0; Tx_Valid = 1'b0; Tx_Data = 8'h00;
      Tx_Last = 1'b0; Tx_AbortFrame = 1'b0;
      repeat (3) @(negedge Clk);
      check_idle("reset");
      Rst = 1'b0;
      TxEN = 1'b1;
      Tx_AbortFrame = 1'b1;
      repeat (3) begin
         @(negedge Clk);
         check_idle("abort_in_idle");
      end
      Tx_AbortFrame = 1'b0;
      @(negedge Clk);
   endtask

   task automatic test_flag_byte;
      bq_t d;
      d = '{8'h7E};
      frame_ok(d, "byte_7e");
   endtask

   task automatic test_ones;
      bq_t d;
      d = '{8'hFF, 8'hFF};
      frame_ok(d, "bytes_ff_ff");
   endtask

   task automatic test_back_to_back;
      bq_t d;
      d = '{8'h3E, 8'hF8, 8'h1F};
      frame_ok(d, "b2b_first");
      d = '{8'hC3};
      frame_ok(d, "b2b_second");
   endtask

   task automatic test_abort;
      bq_t d;
      d = '{8'h55, 8'hAA, 8'h33, 8'hCC};
      // pos 0 idle, 1..8 flag, 9..11 payload bits 0..2
      run_frame(d, 4, 11, 1, "abort_req");
      repeat (2) begin
         @(negedge Clk);
         check_idle("after_abort");
      end
   endtask

   task automatic test_underrun;
      bq_t d;
      d = '{8'h12, 8'h34, 8'h56};
      run_frame(d, 1, -1, 1, "underrun");
   endtask

`ifdef HDLC_TX_FCS_EN
   task automatic test_fcs;
      bq_t d, want;
      d = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      run_frame(d, d.size(), -1, d.size(), "fcs_check");
      want = d;
      want.push_back(8'h6E);
      want.push_back(8'h90);
      rx_check(want, "fcs_check");
   endtask
`endif

   task automatic test_reset_mid;
      bq_t d;
      TxEN = 1'b1; Tx_Valid = 1'b1; Tx_Data = 8'h00; Tx_Last = 1'b0;
      repeat (14) @(negedge Clk);
      checks++;
      if (Tx_Busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid busy_before: %b required 1", Tx_Busy);
      end
      Rst = 1'b1;
      Tx_Valid = 1'b0;
      @(posedge Clk);
      #1;
      check_idle("reset_mid_edge");
      Rst = 1'b0;
      repeat (10) begin
         @(negedge Clk);
         check_idle("reset_mid_after");
      end
      d = '{8'hA5, 8'h3C};
      frame_ok(d, "after_reset");
   endtask

   initial begin
      test_reset;
      test_flag_byte;
      test_ones;
      test_back_to_back;
      test_abort;
      test_underrun;
`ifdef HDLC_TX_FCS_EN
      test_fcs;
`endif
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
